// File: rtl/rd_writeback_ctrl_if.sv
// rd_writeback_ctrl_if: execute, load-unit and
// register-file write-port signals of the Rd writeback block.
interface rd_writeback_ctrl_if;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [1:0]  ex_sel;
  logic [31:0] ex_pc4;
  logic [31:0] ex_pcimm;
  logic [31:0] ex_imm;
  logic [31:0] ex_alu;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        ld_pending;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output ex_valid, ex_rd, ex_rs1, ex_rs2,
    output ex_sel, ex_pc4, ex_pcimm,
    output ex_imm, ex_alu,
    output ld_issue, ld_rd, ld_funct3,
    output ld_addr_lo, mem_rvalid, mem_rdata,
    input  stall, ld_pending,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  ex_valid, ex_rd, ex_rs1, ex_rs2,
    input  ex_sel, ex_pc4, ex_pcimm,
    input  ex_imm, ex_alu,
    input  ld_issue, ld_rd, ld_funct3,
    input  ld_addr_lo, mem_rvalid, mem_rdata,
    output stall, ld_pending,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rd_writeback_ctrl.sv
// rd_writeback_ctrl: single register-file write port
// shared by execute results and one outstanding load.
module rd_writeback_ctrl (
  input logic             clk,
  input logic             rst,
  rd_writeback_ctrl_if.slave wb
);

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [4:0]  pend_rd;
  logic [2:0]  pend_funct3;
  logic [1:0]  pend_lo;
  logic        hold_valid;
  logic [4:0]  hold_rd;
  logic [31:0] hold_data;

  logic        in_wait;
  logic        raw_hit;
  logic        ex_acc;
  logic        ld_acc;
  logic        ret;
  logic        ret_we;
  logic [31:0] ex_val;
  logic [31:0] ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  logic        we_nx;
  logic [4:0]  waddr_nx;
  logic [31:0] wdata_nx;
  logic        hold_set;
  logic        hold_valid_nx;

  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;

  assign in_wait = (state == LOAD_WAIT);

  assign raw_hit = wb.ex_valid
                 & (pend_rd != 5'd0)
                 & ((pend_rd == wb.ex_rs1)
                  | (pend_rd == wb.ex_rs2)
                  | (pend_rd == wb.ex_rd));

  assign wb.stall = ~rst & (hold_valid
                  | (in_wait & wb.ld_issue)
                  | (in_wait & raw_hit));

  // x0 writes are accepted but never claim the port
  assign ex_acc = wb.ex_valid & ~wb.stall
                & (wb.ex_rd != 5'd0);
  assign ld_acc = wb.ld_issue & ~wb.stall & ~in_wait;
  assign ret    = in_wait & wb.mem_rvalid;
  assign ret_we = ret & (pend_rd != 5'd0);

  assign wb.ld_pending = in_wait;
  assign wb.rf_we      = rf_we_q;
  assign wb.rf_waddr   = rf_waddr_q;
  assign wb.rf_wdata   = rf_wdata_q;

  // Execute result select
  always_comb begin
    ex_val = wb.ex_alu;
    unique case (wb.ex_sel)
      2'b00: ex_val = wb.ex_pc4;
      2'b01: ex_val = wb.ex_pcimm;
      2'b10: ex_val = wb.ex_imm;
      2'b11: ex_val = wb.ex_alu;
    endcase
  end

  // Load data extraction from the aligned word
  always_comb begin
    ld_byte = wb.mem_rdata[7:0];
    unique case (pend_lo)
      2'd0: ld_byte = wb.mem_rdata[7:0];
      2'd1: ld_byte = wb.mem_rdata[15:8];
      2'd2: ld_byte = wb.mem_rdata[23:16];
      2'd3: ld_byte = wb.mem_rdata[31:24];
    endcase
    ld_half = pend_lo[1] ? wb.mem_rdata[31:16]
                         : wb.mem_rdata[15:0];
    case (pend_funct3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = wb.mem_rdata;
    endcase
  end

  // Next state and port arbitration: load > hold > execute
  always_comb begin
    state_nx = state;
    we_nx    = 1'b0;
    waddr_nx = rf_waddr_q;
    wdata_nx = rf_wdata_q;
    hold_set = 1'b0;
    unique case (state)
      IDLE:      if (ld_acc) state_nx = LOAD_WAIT;
      LOAD_WAIT: if (wb.mem_rvalid) state_nx = IDLE;
    endcase
    if (ret_we) begin
      we_nx    = 1'b1;
      waddr_nx = pend_rd;
      wdata_nx = ld_val;
      hold_set = ex_acc;
    end else if (hold_valid) begin
      we_nx    = 1'b1;
      waddr_nx = hold_rd;
      wdata_nx = hold_data;
    end else if (ex_acc) begin
      we_nx    = 1'b1;
      waddr_nx = wb.ex_rd;
      wdata_nx = ex_val;
    end
    hold_valid_nx = hold_set | (hold_valid & ret_we);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Pending load, hold buffer and write port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_rd     <= 5'd0;
      pend_funct3 <= 3'd0;
      pend_lo     <= 2'd0;
      hold_valid  <= 1'b0;
      hold_rd     <= 5'd0;
      hold_data   <= 32'd0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 5'd0;
      rf_wdata_q  <= 32'd0;
    end else begin
      if (ld_acc) begin
        pend_rd     <= wb.ld_rd;
        pend_funct3 <= wb.ld_funct3;
        pend_lo     <= wb.ld_addr_lo;
      end
      hold_valid <= hold_valid_nx;
      if (hold_set) begin
        hold_rd   <= wb.ex_rd;
        hold_data <= ex_val;
      end
      rf_we_q    <= we_nx;
      rf_waddr_q <= waddr_nx;
      rf_wdata_q <= wdata_nx;
    end
  end

endmodule

// File: tb/tb_rd_writeback_ctrl.sv
// tb_rd_writeback_ctrl: scoreboard bench for the
// Rd writeback port controller.
module tb_rd_writeback_ctrl;

  logic clk;
  logic rst;
  int   ncmp;
  int   nerr;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t q[$];

  rd_writeback_ctrl_if bus ();

  rd_writeback_ctrl dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every port write must match the queue head
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      ncmp++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_write got %0d/%h required none",
                 bus.rf_waddr, bus.rf_wdata);
      end else begin
        wr_t e;
        e = q.pop_front();
        if (bus.rf_waddr !== e.a || bus.rf_wdata !== e.d) begin
          nerr++;
          $display("FAIL sb_write got %0d/%h required %0d/%h",
                   bus.rf_waddr, bus.rf_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.ex_valid   = 1'b0;
    bus.ex_rd      = 5'd0;
    bus.ex_rs1     = 5'd0;
    bus.ex_rs2     = 5'd0;
    bus.ex_sel     = 2'd0;
    bus.ex_pc4     = 32'd0;
    bus.ex_pcimm   = 32'd0;
    bus.ex_imm     = 32'd0;
    bus.ex_alu     = 32'd0;
    bus.ld_issue   = 1'b0;
    bus.ld_rd      = 5'd0;
    bus.ld_funct3  = 3'd0;
    bus.ld_addr_lo = 2'd0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
  endtask

  task automatic issue_lw(input logic [4:0] rd);
    bus.ld_issue  = 1'b1;
    bus.ld_rd     = rd;
    bus.ld_funct3 = 3'b010;
    step();
    bus.ld_issue  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    ncmp++;
    if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 ||
        bus.rf_wdata !== 32'd0) begin
      nerr++;
      $display("FAIL reset_port got %b/%0d/%h required 0/0/0",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    ncmp++;
    if (bus.ld_pending !== 1'b0 || bus.stall !== 1'b0) begin
      nerr++;
      $display("FAIL reset_status got %b/%b required 0/0",
               bus.ld_pending, bus.stall);
    end
    step();
  endtask

  task automatic test_ex_write();
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 5'd5;
    bus.ex_sel   = 2'b10;
    bus.ex_imm   = 32'h1234_5000;
    push(5'd5, 32'h1234_5000);
    step();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    ncmp++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5) begin
      nerr++;
      $display("FAIL ex_latency got %b/%0d required 1/5",
               bus.rf_we, bus.rf_waddr);
    end
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 5'd0;
    step();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    ncmp++;
    if (bus.rf_we !== 1'b0) begin
      nerr++;
      $display("FAIL ex_x0 got %b required 0", bus.rf_we);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      bus.ex_valid = 1'b1;
      bus.ex_rd    = 5'(i + 1);
      bus.ex_sel   = 2'(i);
      bus.ex_pc4   = 32'h100 + i;
      bus.ex_pcimm = 32'h2000 + i;
      bus.ex_imm   = 32'h30000 + i;
      bus.ex_alu   = 32'h400000 + i;
      case (i)
        0:       v = 32'h100 + i;
        1:       v = 32'h2000 + i;
        2:       v = 32'h30000 + i;
        default: v = 32'h400000 + i;
      endcase
      push(5'(i + 1), v);
      step();
      @(negedge clk);
      ncmp++;
      if (bus.rf_we !== 1'b1) begin
        nerr++;
        $display("FAIL b2b_we%0d got %b required 1", i, bus.rf_we);
      end
    end
    bus.ld_issue  = 1'b1;
    bus.ld_rd     = 5'd12;
    bus.ld_funct3 = 3'b010;
    bus.ex_rd     = 5'd13;
    bus.ex_sel    = 2'b11;
    bus.ex_alu    = 32'hABCD;
    push(5'd13, 32'hABCD);
    step();
    idle_inputs();
    @(negedge clk);
    ncmp++;
    if (bus.ld_pending !== 1'b1) begin
      nerr++;
      $display("FAIL dual_accept got %b required 1", bus.ld_pending);
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0BAD_F00D;
    push(5'd12, 32'h0BAD_F00D);
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_load_extract();
    logic [2:0]  f3 [7];
    logic [1:0]  lo [7];
    logic [31:0] rd [7];
    logic [31:0] ex [7];
    f3[0] = 3'b000; lo[0] = 2; rd[0] = 32'h0080_0000;
    ex[0] = 32'hFFFF_FF80;
    f3[1] = 3'b101; lo[1] = 2; rd[1] = 32'h8001_0000;
    ex[1] = 32'h0000_8001;
    f3[2] = 3'b001; lo[2] = 2; rd[2] = 32'h8001_0000;
    ex[2] = 32'hFFFF_8001;
    f3[3] = 3'b100; lo[3] = 1; rd[3] = 32'h0000_FF00;
    ex[3] = 32'h0000_00FF;
    f3[4] = 3'b010; lo[4] = 0; rd[4] = 32'hDEAD_BEEF;
    ex[4] = 32'hDEAD_BEEF;
    f3[5] = 3'b011; lo[5] = 3; rd[5] = 32'hCAFE_F00D;
    ex[5] = 32'hCAFE_F00D;
    f3[6] = 3'b001; lo[6] = 0; rd[6] = 32'h0000_7FFF;
    ex[6] = 32'h0000_7FFF;
    for (int i = 0; i < 7; i++) begin
      bus.ld_issue   = 1'b1;
      bus.ld_rd      = 5'd7;
      bus.ld_funct3  = f3[i];
      bus.ld_addr_lo = lo[i];
      step();
      bus.ld_issue   = 1'b0;
      @(negedge clk);
      ncmp++;
      if (bus.ld_pending !== 1'b1) begin
        nerr++;
        $display("FAIL ld_pend%0d got %b required 1", i, bus.ld_pending);
      end
      step();
      step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rd[i];
      push(5'd7, ex[i]);
      step();
      bus.mem_rvalid = 1'b0;
      @(negedge clk);
      ncmp++;
      if (bus.rf_we !== 1'b1 || bus.ld_pending !== 1'b0) begin
        nerr++;
        $display("FAIL ld_ret%0d got we=%b pend=%b required 1/0",
                 i, bus.rf_we, bus.ld_pending);
      end
    end
    bus.mem_rvalid = 1'b1;
    step();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    ncmp++;
    if (bus.rf_we !== 1'b0) begin
      nerr++;
      $display("FAIL rvalid_idle got %b required 0", bus.rf_we);
    end
    step();
  endtask

  task automatic test_hazard();
    issue_lw(5'd7);
    bus.ex_valid = 1'b1;
    bus.ex_rs2   = 5'd7;
    bus.ex_rd    = 5'd9;
    bus.ex_sel   = 2'b11;
    bus.ex_alu   = 32'h55;
    @(negedge clk);
    ncmp++;
    if (bus.stall !== 1'b1) begin
      nerr++;
      $display("FAIL hz_stall got %b required 1", bus.stall);
    end
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h7777;
    push(5'd7, 32'h7777);
    @(negedge clk);
    ncmp++;
    if (bus.stall !== 1'b1) begin
      nerr++;
      $display("FAIL hz_ret_stall got %b required 1", bus.stall);
    end
    step();
    bus.mem_rvalid = 1'b0;
    push(5'd9, 32'h55);
    @(negedge clk);
    ncmp++;
    if (bus.stall !== 1'b0) begin
      nerr++;
      $display("FAIL hz_release got %b required 0", bus.stall);
    end
    step();
    idle_inputs();
    @(negedge clk);
    ncmp++;
    if (bus.rf_waddr !== 5'd9) begin
      nerr++;
      $display("FAIL hz_write got %0d required 9", bus.rf_waddr);
    end
    issue_lw(5'd7);
    bus.ex_valid = 1'b1;
    bus.ex_rs1   = 5'd1;
    bus.ex_rs2   = 5'd2;
    bus.ex_rd    = 5'd3;
    bus.ex_sel   = 2'b01;
    bus.ex_pcimm = 32'h8000_0010;
    push(5'd3, 32'h8000_0010);
    @(negedge clk);
    ncmp++;
    if (bus.stall !== 1'b0) begin
      nerr++;
      $display("FAIL hz_indep got %b required 0", bus.stall);
    end
    step();
    idle_inputs();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1;
    push(5'd7, 32'h1);
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_collision();
    issue_lw(5'd3);
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hAA;
    bus.ex_valid   = 1'b1;
    bus.ex_rd      = 5'd4;
    bus.ex_sel     = 2'b00;
    bus.ex_pc4     = 32'h104;
    push(5'd3, 32'hAA);
    push(5'd4, 32'h104);
    step();
    idle_inputs();
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 5'd8;
    bus.ex_sel   = 2'b10;
    bus.ex_imm   = 32'h77;
    push(5'd8, 32'h77);
    @(negedge clk);
    ncmp++;
    if (bus.stall !== 1'b1 || bus.rf_waddr !== 5'd3) begin
      nerr++;
      $display("FAIL col_m1 got stall=%b wa=%0d required 1/3",
               bus.stall, bus.rf_waddr);
    end
    step();
    @(negedge clk);
    ncmp++;
    if (bus.stall !== 1'b0 || bus.rf_waddr !== 5'd4 ||
        bus.rf_we !== 1'b1) begin
      nerr++;
      $display("FAIL col_m2 got stall=%b we=%b wa=%0d required 0/1/4",
               bus.stall, bus.rf_we, bus.rf_waddr);
    end
    step();
    idle_inputs();
    @(negedge clk);
    ncmp++;
    if (bus.rf_waddr !== 5'd8) begin
      nerr++;
      $display("FAIL col_m3 got %0d required 8", bus.rf_waddr);
    end
    step();
  endtask

  task automatic test_double_issue();
    issue_lw(5'd10);
    bus.ld_issue = 1'b1;
    bus.ld_rd    = 5'd11;
    @(negedge clk);
    ncmp++;
    if (bus.stall !== 1'b1) begin
      nerr++;
      $display("FAIL dbl_stall got %b required 1", bus.stall);
    end
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234;
    push(5'd10, 32'h1234);
    @(negedge clk);
    ncmp++;
    if (bus.stall !== 1'b1) begin
      nerr++;
      $display("FAIL dbl_ret_stall got %b required 1", bus.stall);
    end
    step();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    ncmp++;
    if (bus.stall !== 1'b0 || bus.ld_pending !== 1'b0) begin
      nerr++;
      $display("FAIL dbl_free got %b/%b required 0/0",
               bus.stall, bus.ld_pending);
    end
    step();
    bus.ld_issue = 1'b0;
    @(negedge clk);
    ncmp++;
    if (bus.ld_pending !== 1'b1) begin
      nerr++;
      $display("FAIL dbl_second got %b required 1", bus.ld_pending);
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5678;
    push(5'd11, 32'h5678);
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    issue_lw(5'd3);
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hAA;
    bus.ex_valid   = 1'b1;
    bus.ex_rd      = 5'd4;
    bus.ex_pc4     = 32'h104;
    push(5'd3, 32'hAA);
    step();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    ncmp++;
    if (bus.stall !== 1'b0) begin
      nerr++;
      $display("FAIL rst_stall got %b required 0", bus.stall);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    ncmp++;
    if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 ||
        bus.rf_wdata !== 32'd0 || bus.ld_pending !== 1'b0) begin
      nerr++;
      $display("FAIL rst_hold got %b/%0d/%h/%b required 0/0/0/0",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.ld_pending);
    end
    step();
    issue_lw(5'd9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF;
    step();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    ncmp++;
    if (bus.rf_we !== 1'b0 || bus.ld_pending !== 1'b0) begin
      nerr++;
      $display("FAIL rst_load got %b/%b required 0/0",
               bus.rf_we, bus.ld_pending);
    end
    step();
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    rst  = 1'b1;
    idle_inputs();
    test_reset();
    test_ex_write();
    test_back_to_back();
    test_load_extract();
    test_hazard();
    test_collision();
    test_double_issue();
    test_reset_mid();
    step();
    step();
    ncmp++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL sb_drain got %0d left required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
